perm_pipe_engine: RTL

- Parametrised successor of the fixed 8-bit decrypt permutation stage.
- Applies a run-time programmable bit permutation (encrypt or inverse/decrypt, selected per beat) over ROUNDS pipelined rounds, with valid/ready backpressure.
- Contains a serial key-load interface and a bijection checker that rejects invalid tables.
- Sits between the byte source and the substitution stages of the encrypter/decrypter datapath.

---
 rtl/perm_pipe_pkg.sv | 39 +++
 rtl/perm_pipe_engine_if.sv | 41 ++++
 rtl/perm_pipe_engine_round.sv | 58 +++++
 rtl/perm_pipe_engine.sv | 126 ++++++++++++
 4 files changed

// File: rtl/perm_pipe_pkg.sv
// Shared types and the round mapping for the permutation pipeline.
// Mapping works on max-width words so one function serves any DATA_W.
package perm_pipe_pkg;

  localparam int MAX_W  = 64;
  localparam int MAX_IW = 6;

  typedef logic [MAX_W-1:0]             word_t;
  typedef logic [MAX_W-1:0][MAX_IW-1:0] tbl_t;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    LOAD,
    CHECK,
    ERROR
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic word_t perm_apply(
    input word_t x,
    input tbl_t  tbl,
    input logic  mode,
    input int    n
  );
    word_t y;
    y = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) begin
        if (mode == MODE_DEC) y[tbl[i]] = x[i];
        else                  y[i] = x[tbl[i]];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/perm_pipe_engine_if.sv
// Config and data-stream bundle of the permutation engine.
// slave = engine side, master = driver side.
interface perm_pipe_engine_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DATA_W)
);

  logic              cfg_start;
  logic              cfg_wr;
  logic [IDX_W-1:0]  cfg_idx;
  logic [IDX_W-1:0]  cfg_data;
  logic              cfg_done;
  logic              cfg_busy;
  logic              perm_err;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  cfg_start, cfg_wr, cfg_idx,
    input  cfg_data, cfg_done,
    input  in_valid, in_mode, data_in,
    input  out_ready,
    output cfg_busy, perm_err, in_ready,
    output out_valid, data_out
  );

  modport master (
    output cfg_start, cfg_wr, cfg_idx,
    output cfg_data, cfg_done,
    output in_valid, in_mode, data_in,
    output out_ready,
    input  cfg_busy, perm_err, in_ready,
    input  out_valid, data_out
  );

endinterface

// File: rtl/perm_pipe_engine_round.sv
// One permutation round: combinational mapping into a
// stage register that holds while the pipeline is stalled.
module perm_round
  import perm_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv,
  input  logic [DATA_W-1:0][IDX_W-1:0] tbl,
  input  logic                         v_i,
  input  logic                         mode_i,
  input  logic [DATA_W-1:0]            d_i,
  output logic                         v_o,
  output logic                         mode_o,
  output logic [DATA_W-1:0]            d_o
);

  logic              v_d, v_q;
  logic              mode_d, mode_q;
  logic [DATA_W-1:0] d_d, d_q;
  tbl_t              tw;

  always_comb begin
    tw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      tw[i] = MAX_IW'(tbl[i]);
    end
    v_d    = v_q;
    mode_d = mode_q;
    d_d    = d_q;
    if (adv) begin
      v_d    = v_i;
      mode_d = mode_i;
      d_d    = DATA_W'(perm_apply(word_t'(d_i), tw,
                                  mode_i, DATA_W));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= 1'b0;
      mode_q <= MODE_ENC;
      d_q    <= '0;
    end else begin
      v_q    <= v_d;
      mode_q <= mode_d;
      d_q    <= d_d;
    end
  end

  assign v_o    = v_q;
  assign mode_o = mode_q;
  assign d_o    = d_q;

endmodule

// File: rtl/perm_pipe_engine.sv
// Programmable bit-permutation pipeline with serial table load
// and a bijection check before the new table goes live.
module perm_pipe_engine
  import perm_pipe_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ROUNDS = 1,
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input logic         clk,
  input logic         rst,
  perm_pipe_engine_if.slave bus
);

  logic [DATA_W-1:0][IDX_W-1:0] tbl_d, tbl_q, ident;
  state_t                       state_d, state_q;
  logic [IDX_W-1:0]             k_d, k_q;
  logic [DATA_W-1:0]            seen_d, seen_q;

  logic [ROUNDS:0]             v;
  logic [ROUNDS:0]             m;
  logic [ROUNDS:0][DATA_W-1:0] d;
  logic                        stall, fire_in, pipe_busy;

  assign stall     = v[ROUNDS] && !bus.out_ready;
  assign fire_in   = bus.in_valid && bus.in_ready;
  assign pipe_busy = |v[ROUNDS:1];
  assign v[0]      = fire_in;
  assign m[0]      = bus.in_mode;
  assign d[0]      = bus.data_in;

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    perm_round #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_round (
      .clk    (clk),
      .rst    (rst),
      .adv    (!stall),
      .tbl    (tbl_q),
      .v_i    (v[r]),
      .mode_i (m[r]),
      .d_i    (d[r]),
      .v_o    (v[r+1]),
      .mode_o (m[r+1]),
      .d_o    (d[r+1])
    );
  end

  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      ident[i] = IDX_W'(i);
    end
    state_d = state_q;
    tbl_d   = tbl_q;
    k_d     = k_q;
    seen_d  = seen_q;
    unique case (state_q)
      RUN: begin
        // a beat accepted on this edge still needs draining
        if (bus.cfg_start) begin
          if (pipe_busy || fire_in) begin
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
            tbl_d   = ident;
          end
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          state_d = LOAD;
          tbl_d   = ident;
        end
      end
      LOAD: begin
        if (bus.cfg_done) begin
          state_d = CHECK;
          k_d     = '0;
          seen_d  = '0;
        end else if (bus.cfg_wr) begin
          tbl_d[bus.cfg_idx] = bus.cfg_data;
        end
      end
      CHECK: begin
        if (seen_q[tbl_q[k_q]]) begin
          state_d = ERROR;
        end else begin
          seen_d[tbl_q[k_q]] = 1'b1;
          if (k_q == IDX_W'(DATA_W-1)) state_d = RUN;
          else                         k_d = k_q + 1'b1;
        end
      end
      ERROR: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          tbl_d   = ident;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      tbl_q   <= ident;
      k_q     <= '0;
      seen_q  <= '0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      k_q     <= k_d;
      seen_q  <= seen_d;
    end
  end

  assign bus.in_ready  = (state_q == RUN) && !stall;
  assign bus.out_valid = v[ROUNDS];
  assign bus.data_out  = d[ROUNDS];
  assign bus.perm_err  = (state_q == ERROR);
  assign bus.cfg_busy  = (state_q == DRAIN) ||
                         (state_q == LOAD) ||
                         (state_q == CHECK);

endmodule
